// File: rtl/multiplier_sa_if.sv
// Handshake and data bundle between a pipeline stage and the iterative multiplier.
interface multiplier_sa_if;
    logic        start;
    logic        sign;
    logic        flush;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, sign, flush, srca, srcb,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, sign, flush, srca, srcb,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/multiplier_sa.sv
// Radix-2 shift-add 32x32 multiplier (MULT/MULTU): 32 iterations, one-cycle done pulse.
module multiplier_sa (
    input logic            clk,
    input logic            resetn,
    multiplier_sa_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic        neg;
    logic [4:0]  cnt;
    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc_next;
    logic [63:0] product;

    // Signed mode works on magnitudes; 0x80000000 maps to itself as an unsigned value.
    always_comb begin
        mag_a    = (bus.sign && bus.srca[31]) ? (~bus.srca + 32'd1) : bus.srca;
        mag_b    = (bus.sign && bus.srcb[31]) ? (~bus.srcb + 32'd1) : bus.srcb;
        acc_next = acc + (mplier[0] ? mcand : '0);
        product  = neg ? (~acc_next + 64'd1) : acc_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            if (bus.flush) begin
                state  <= IDLE;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            mcand  <= {32'd0, mag_a};
                            mplier <= mag_b;
                            neg    <= bus.sign & (bus.srca[31] ^ bus.srcb[31]);
                            acc    <= '0;
                            cnt    <= '0;
                            busy_r <= 1'b1;
                            state  <= CALC;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                    CALC: begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 5'd1;
                        // Final iteration folds its partial product straight into hi/lo.
                        if (cnt == 5'd31) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            hi_r   <= product[63:32];
                            lo_r   <= product[31:0];
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_multiplier_sa.sv
// Randomized and directed checks of multiplier_sa against a plain-arithmetic product model.
module tb_multiplier_sa;
    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

    multiplier_sa_if bus ();

    multiplier_sa dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            sp = sa * sb;
            return sp;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Issues one operation and follows it to done; returns after sampling the done cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output logic [31:0] h, output logic [31:0] l,
                         output logic busy_ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sign  = s;
        bus.srca  = a;
        bus.srcb  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.srca  = $urandom;
        bus.srcb  = $urandom;
        busy_ok   = bus.busy;
        lat       = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end
        h = bus.hi;
        l = bus.lo;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        n_tests++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", bus.done); end
        n_tests++;
        if ({bus.hi, bus.lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo got=%h want=0", {bus.hi, bus.lo}); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vs [4];
        logic [63:0] want [4];
        int          lat;
        logic [31:0] h;
        logic [31:0] l;
        logic        bok;
        va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; vs[0] = 1'b0; want[0] = 64'hFFFFFFFE_00000001;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'h00000001; vs[1] = 1'b1; want[1] = 64'hFFFFFFFF_FFFFFFFF;
        va[2] = 32'h80000000; vb[2] = 32'h80000000; vs[2] = 1'b1; want[2] = 64'h40000000_00000000;
        va[3] = 32'h80000000; vb[3] = 32'h00000001; vs[3] = 1'b1; want[3] = 64'hFFFFFFFF_80000000;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vs[i], lat, h, l, bok);
            n_tests++;
            if (lat !== 32) begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=32", i, lat); end
            n_tests++;
            if (bok !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy got=%b want=1", i, bok); end
            n_tests++;
            if ({h, l} !== want[i]) begin n_fail++; $display("FAIL dir%0d_product got=%h want=%h", i, {h, l}, want[i]); end
            @(posedge clk);
            #1;
            n_tests++;
            if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width got=%b want=0", i, bus.done); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] want;
        int          lat;
        logic [31:0] h;
        logic [31:0] l;
        logic        bok;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i % 6 == 0) b = 32'd0;
            if (i % 6 == 1) a = 32'd1;
            want = ref_mul(a, b, s);
            do_op(a, b, s, lat, h, l, bok);
            n_tests++;
            if (lat !== 32 || bok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_timing lat=%0d busy=%b want 32/1", i, lat, bok); end
            n_tests++;
            if ({h, l} !== want) begin n_fail++; $display("FAIL rnd%0d_product a=%h b=%h s=%b got=%h want=%h", i, a, b, s, {h, l}, want); end
        end
    endtask

    task automatic test_flush();
        int          lat;
        int          dones;
        logic [31:0] h;
        logic [31:0] l;
        logic        bok;
        do_op(32'd3, 32'd5, 1'b0, lat, h, l, bok);
        n_tests++;
        if ({h, l} !== 64'd15) begin n_fail++; $display("FAIL flush_pre got=%h want=15", {h, l}); end
        @(negedge clk);
        bus.start = 1'b1; bus.sign = 1'b0; bus.srca = 32'h12345678; bus.srcb = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b want=0", bus.busy); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dones++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (dones !== 0) begin n_fail++; $display("FAIL flush_done got=%0d want=0", dones); end
        n_tests++;
        if ({bus.hi, bus.lo} !== 64'd15) begin n_fail++; $display("FAIL flush_hold got=%h want=15", {bus.hi, bus.lo}); end
    endtask

    task automatic test_ignore_start();
        int          dones;
        logic [63:0] got;
        @(negedge clk);
        bus.start = 1'b1; bus.sign = 1'b0; bus.srca = 32'd2; bus.srcb = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.srca = 32'd9; bus.srcb = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        got   = '1;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin dones++; got = {bus.hi, bus.lo}; end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (dones !== 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
        n_tests++;
        if (got !== 64'd6) begin n_fail++; $display("FAIL ignore_product got=%h want=6", got); end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] h;
        logic [31:0] l;
        logic        bok;
        do_op(32'd1, 32'd1, 1'b0, lat, h, l, bok);
        // Still inside the DONE cycle: request the next operation immediately.
        bus.start = 1'b1; bus.sign = 1'b0; bus.srca = 32'h00010000; bus.srcb = 32'h00010000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept busy=%b done=%b want 1/0", bus.busy, bus.done); end
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_tests++;
        if (lat !== 32) begin n_fail++; $display("FAIL b2b_latency got=%0d want=32", lat); end
        n_tests++;
        if ({bus.hi, bus.lo} !== ref_mul(32'h00010000, 32'h00010000, 1'b0)) begin
            n_fail++; $display("FAIL b2b_product got=%h want=%h", {bus.hi, bus.lo}, 64'h00000001_00000000);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL startflush_busy got=%b want=0", bus.busy); end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL startflush_idle busy=%b done=%b want 0/0", bus.busy, bus.done); end
    endtask

    task automatic test_async_reset();
        int          lat;
        logic [31:0] h;
        logic [31:0] l;
        logic        bok;
        @(negedge clk);
        bus.start = 1'b1; bus.sign = 1'b0; bus.srca = 32'h12345678; bus.srcb = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl busy=%b done=%b want 0/0", bus.busy, bus.done); end
        n_tests++;
        if ({bus.hi, bus.lo} !== 64'd0) begin n_fail++; $display("FAIL arst_hilo got=%h want=0", {bus.hi, bus.lo}); end
        @(negedge clk);
        resetn = 1'b1;
        do_op(32'h12345678, 32'd0, 1'b0, lat, h, l, bok);
        n_tests++;
        if (lat !== 32) begin n_fail++; $display("FAIL arst_after_latency got=%0d want=32", lat); end
        n_tests++;
        if ({h, l} !== 64'd0) begin n_fail++; $display("FAIL arst_after_product got=%h want=0", {h, l}); end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        resetn    = 1'b1;
        bus.start = 1'b0;
        bus.sign  = 1'b0;
        bus.flush = 1'b0;
        bus.srca  = '0;
        bus.srcb  = '0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multiplier_sa.md
MULTIPLIER_SA -- requirements
Module: multiplier_sa

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32, product width 64.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request new multiply; sampled only when accept-ready (REQ-009).
REQ-005 sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); captured with start.
REQ-006 flush  input  1  abort in-flight operation (pipeline exception/flush).
REQ-007 srca, srcb  input  32 each  operands; captured with start.
REQ-008 busy  output  1  high while a multiply is in progress; done  output  1  one-cycle completion pulse; hi  output  32  product[63:32]; lo  output  32  product[31:0].

Function
REQ-009 SHALL implement FSM states IDLE, CALC, DONE; accept-ready = state is IDLE or DONE.
REQ-010 Accept: start=1, flush=0, accept-ready -> latch operand magnitudes, sign, and result-negate flag; clear 64-bit accumulator and iteration counter; next state CALC.
REQ-011 Magnitudes: sign=1 -> two's-complement absolute value of each operand as 32-bit unsigned (0x80000000 -> 0x80000000); sign=0 -> operand unchanged.
REQ-012 Result-negate flag = sign & (srca[31] ^ srcb[31]).
REQ-013 CALC: radix-2 shift-add, one multiplier bit per cycle, LSB first; exactly 32 CALC cycles, tracked by 5-bit counter 0..31.
REQ-014 After counter = 31 -> next state DONE; 64-bit product negated (two's complement) when negate flag set; hi/lo registered at this transition.
REQ-015 Latency: start accepted at edge T -> done=1 during the cycle after edge T+32 (33 cycles from accept to done); no early termination for zero or small operands.
REQ-016 done SHALL be high only in DONE (exactly one cycle); DONE -> IDLE if no new start, else DONE -> CALC per REQ-010.
REQ-017 busy = (state == CALC); busy SHALL be low in IDLE and DONE.
REQ-018 hi/lo SHALL change only on the CALC -> DONE transition and hold until the next completion.
REQ-019 start while in CALC SHALL be ignored, with no effect on the operation in progress.
REQ-020 flush=1 in any state -> next state IDLE; no done pulse; hi/lo unchanged; accumulator contents discarded.
REQ-021 flush and start in the same cycle: flush wins; start is not accepted.
REQ-022 Operand inputs SHALL not be required stable after the accept cycle.

Reset
REQ-023 resetn=0 -> immediately, without waiting for a clock edge: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, accumulator=0.
REQ-024 resetn deasserted mid-CALC: operation lost, no done; first start after release is accepted normally.

Verification
REQ-025 unsigned 0xFFFFFFFF x 0xFFFFFFFF, start at edge T -> busy for 32 cycles, done pulse after edge T+32, hi=0xFFFFFFFE, lo=0x00000001.
REQ-026 signed 0xFFFFFFFF x 0x00000001 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF; signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; signed 0x80000000 x 0x00000001 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-027 complete 3x5 (hi=0, lo=15), then start 0x12345678 x 7 and assert flush on the 10th CALC cycle -> busy low next cycle, no done pulse, hi=0, lo=15 retained.
REQ-028 during CALC of 2x3, pulse start with 9x9 -> second start ignored; result hi=0, lo=6; done pulses exactly once.
REQ-029 start in the DONE cycle with unsigned 0x00010000 x 0x00010000 -> back-to-back accept, next done 33 cycles later with hi=0x00000001, lo=0; asserting start and flush together in IDLE -> no accept, busy stays 0.
REQ-030 assert resetn=0 asynchronously mid-CALC -> busy/done/hi/lo go to 0 before the next clock edge; after release, unsigned 0x12345678 x 0 -> done after 33 cycles, hi=0, lo=0.
